// File: rtl/conv_group_accum_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv_group_accum_scheduler_if
//
// Bundles every non-clock signal of the convolution group/accumulate
// scheduler. The "slave" modport is the scheduler's view. The "master"
// modport is the view of the surrounding system (job control, window/weight
// source, datapath return path and the downstream consumer).
//
// Signal summary (scheduler direction):
//   in : start, cfg_num_groups, cfg_num_pixels   job control
//   out: busy, done                              job status
//   in : src_valid   out: src_ready              window/weight beat handshake
//   out: grp_idx, pix_idx, dp_valid              datapath issue
//   in : dp_sum_valid, dp_sum_a, dp_sum_b        datapath per-group return
//   out: out_valid, out_sum_a, out_sum_b, out_last   accumulated pixel stream
//   in : out_ready
//   out: err_underflow                           sticky return-without-issue
// ---------------------------------------------------------------------------
interface conv_group_accum_scheduler_if #(
    parameter int SUM_WIDTH      = 35,
    parameter int NUM_GROUPS_MAX = 16,
    parameter int OUT_WIDTH      = SUM_WIDTH + $clog2(NUM_GROUPS_MAX),
    parameter int GW             = $clog2(NUM_GROUPS_MAX + 1)
);
    logic                        start;
    logic [GW-1:0]               cfg_num_groups;
    logic [15:0]                 cfg_num_pixels;
    logic                        busy;
    logic                        done;
    logic                        src_valid;
    logic                        src_ready;
    logic [GW-1:0]               grp_idx;
    logic [15:0]                 pix_idx;
    logic                        dp_valid;
    logic                        dp_sum_valid;
    logic signed [SUM_WIDTH-1:0] dp_sum_a;
    logic signed [SUM_WIDTH-1:0] dp_sum_b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_sum_a;
    logic signed [OUT_WIDTH-1:0] out_sum_b;
    logic                        out_last;
    logic                        err_underflow;

    modport slave (
        input  start, cfg_num_groups, cfg_num_pixels,
        output busy, done,
        input  src_valid,
        output src_ready, grp_idx, pix_idx, dp_valid,
        input  dp_sum_valid, dp_sum_a, dp_sum_b,
        output out_valid, out_sum_a, out_sum_b, out_last,
        input  out_ready,
        output err_underflow
    );

    modport master (
        output start, cfg_num_groups, cfg_num_pixels,
        input  busy, done,
        output src_valid,
        input  src_ready, grp_idx, pix_idx, dp_valid,
        output dp_sum_valid, dp_sum_a, dp_sum_b,
        input  out_valid, out_sum_a, out_sum_b, out_last,
        output out_ready,
        input  err_underflow
    );
endinterface

// File: rtl/conv_group_accum_scheduler.sv
// ---------------------------------------------------------------------------
// conv_group_accum_scheduler
//
// Splits every output pixel of a convolution job into cfg_num_groups
// channel-group beats for a non-stallable datapath. It accumulates the
// returned per-group sum pairs and queues finished pixels in a small
// first-word-fall-through FIFO behind a ready/valid output. Because the
// datapath can never be stalled, a new pixel is only started when the FIFO
// is guaranteed to have room for it (credit = free slots minus pixels in
// flight).
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  conv_group_accum_scheduler_if.slave (job control, source handshake,
//        datapath issue/return, output stream, error flag)
// ---------------------------------------------------------------------------
module conv_group_accum_scheduler #(
    parameter int SUM_WIDTH      = 35,
    parameter int NUM_GROUPS_MAX = 16,
    parameter int OUT_WIDTH      = SUM_WIDTH + $clog2(NUM_GROUPS_MAX),
    parameter int FIFO_DEPTH     = 4,
    parameter int GW             = $clog2(NUM_GROUPS_MAX + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    conv_group_accum_scheduler_if.slave        bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    // Occupancy = fifo_count + pixels_in_flight can reach 2*FIFO_DEPTH
    // transiently in the arithmetic, so leave one spare bit.
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int BW = $clog2(FIFO_DEPTH * NUM_GROUPS_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_done_next;

    logic [GW-1:0]         r_num_groups;
    logic [15:0]           r_num_pixels;
    logic [GW-1:0]         r_grp_idx;
    logic [15:0]           r_pix_idx;
    logic [15:0]           r_ret_pix;
    logic [GW-1:0]         r_rg;
    logic [CW-1:0]         r_pif;
    logic [CW-1:0]         r_count;
    logic [BW-1:0]         r_beats;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic signed [OUT_WIDTH-1:0] r_acc_a;
    logic signed [OUT_WIDTH-1:0] r_acc_b;
    logic                  r_done;
    logic                  r_err;

    logic signed [OUT_WIDTH-1:0] r_fifo_a    [FIFO_DEPTH];
    logic signed [OUT_WIDTH-1:0] r_fifo_b    [FIFO_DEPTH];
    logic                        r_fifo_last [FIFO_DEPTH];

    logic                  w_start_ok;
    logic [GW-1:0]         w_cfg_groups;
    logic [CW-1:0]         w_occupied;
    logic                  w_src_ready;
    logic                  w_issue;
    logic                  w_issue_new_pix;
    logic                  w_grp_last;
    logic                  w_last_beat;
    logic                  w_ret_ok;
    logic                  w_underflow;
    logic                  w_push;
    logic                  w_push_last;
    logic                  w_pop;
    logic [CW-1:0]         w_pif_next;
    logic [CW-1:0]         w_count_next;
    logic signed [OUT_WIDTH-1:0] w_sext_a;
    logic signed [OUT_WIDTH-1:0] w_sext_b;
    logic signed [OUT_WIDTH-1:0] w_sum_a;
    logic signed [OUT_WIDTH-1:0] w_sum_b;

    // ---------------- issue side ----------------
    assign w_start_ok   = bus.start && (r_state == S_IDLE);
    assign w_cfg_groups = (bus.cfg_num_groups == '0) ? GW'(1) : bus.cfg_num_groups;

    assign w_occupied  = r_count + r_pif;
    // Later groups of an already-credited pixel never need a fresh credit.
    assign w_src_ready = (r_state == S_RUN) &&
                         ((r_grp_idx != '0) || (w_occupied < CW'(FIFO_DEPTH)));
    assign w_issue         = bus.src_valid && w_src_ready;
    assign w_issue_new_pix = w_issue && (r_grp_idx == '0);
    assign w_grp_last      = (r_grp_idx == r_num_groups - GW'(1));
    assign w_last_beat     = w_issue && w_grp_last &&
                             (r_pix_idx == r_num_pixels - 16'd1);

    // ---------------- return side ----------------
    // A return with nothing outstanding is flagged and otherwise ignored so
    // it cannot corrupt an accumulation in progress.
    assign w_ret_ok    = bus.dp_sum_valid && (r_beats != '0);
    assign w_underflow = bus.dp_sum_valid && (r_beats == '0);
    assign w_push      = w_ret_ok && (r_rg == r_num_groups - GW'(1));
    assign w_push_last = (r_ret_pix == r_num_pixels - 16'd1);
    assign w_pop       = (r_count != '0) && bus.out_ready;

    assign w_sext_a = {{(OUT_WIDTH-SUM_WIDTH){bus.dp_sum_a[SUM_WIDTH-1]}}, bus.dp_sum_a};
    assign w_sext_b = {{(OUT_WIDTH-SUM_WIDTH){bus.dp_sum_b[SUM_WIDTH-1]}}, bus.dp_sum_b};
    // Group 0 restarts the accumulator instead of adding to stale data.
    assign w_sum_a  = ((r_rg == '0) ? '0 : r_acc_a) + w_sext_a;
    assign w_sum_b  = ((r_rg == '0) ? '0 : r_acc_b) + w_sext_b;

    assign w_pif_next   = r_pif + CW'(w_issue_new_pix) - CW'(w_push);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // ---------------- FSM next state ----------------
    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.cfg_num_pixels == 16'd0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_last_beat) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looking at next-cycle occupancy lets done coincide with
                // the first cycle after the final pop or final return.
                if ((w_pif_next == '0) && (w_count_next == '0)) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_num_groups <= GW'(1);
            r_num_pixels <= 16'd0;
            r_grp_idx    <= '0;
            r_pix_idx    <= 16'd0;
            r_ret_pix    <= 16'd0;
            r_rg         <= '0;
            r_pif        <= '0;
            r_count      <= '0;
            r_beats      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_acc_a      <= '0;
            r_acc_b      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_issue) begin
                if (w_grp_last) begin
                    r_grp_idx <= '0;
                    r_pix_idx <= r_pix_idx + 16'd1;
                end else begin
                    r_grp_idx <= r_grp_idx + GW'(1);
                end
            end

            if (w_ret_ok) begin
                if (w_push) begin
                    r_rg      <= '0;
                    r_ret_pix <= r_ret_pix + 16'd1;
                end else begin
                    r_rg    <= r_rg + GW'(1);
                    r_acc_a <= w_sum_a;
                    r_acc_b <= w_sum_b;
                end
            end

            r_pif   <= w_pif_next;
            r_count <= w_count_next;
            r_beats <= r_beats + BW'(w_issue) - BW'(w_ret_ok);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            if (w_underflow) begin
                r_err <= 1'b1;
            end

            // Start overrides everything above; nothing is outstanding in IDLE.
            if (w_start_ok) begin
                r_num_groups <= w_cfg_groups;
                r_num_pixels <= bus.cfg_num_pixels;
                r_grp_idx    <= '0;
                r_pix_idx    <= 16'd0;
                r_ret_pix    <= 16'd0;
                r_rg         <= '0;
                r_err        <= 1'b0;
            end
        end
    end

    // ---------------- FIFO storage (no reset needed; guarded by count) ----
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]    <= w_sum_a;
            r_fifo_b[r_wr_ptr]    <= w_sum_b;
            r_fifo_last[r_wr_ptr] <= w_push_last;
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = r_done;
    assign bus.src_ready     = w_src_ready;
    assign bus.dp_valid      = w_issue;
    assign bus.grp_idx       = r_grp_idx;
    assign bus.pix_idx       = r_pix_idx;
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_sum_a     = (r_count != '0) ? r_fifo_a[r_rd_ptr] : '0;
    assign bus.out_sum_b     = (r_count != '0) ? r_fifo_b[r_rd_ptr] : '0;
    assign bus.out_last      = (r_count != '0) ? r_fifo_last[r_rd_ptr] : 1'b0;
    assign bus.err_underflow = r_err;

endmodule

// File: tb/tb_conv_group_accum_scheduler.sv
`timescale 1ns/1ps
module tb_conv_group_accum_scheduler;
    localparam int SUM_WIDTH      = 35;
    localparam int NUM_GROUPS_MAX = 16;
    localparam int OUT_WIDTH      = 39;
    localparam int FIFO_DEPTH     = 4;
    localparam int GW             = 5;
    localparam int LAT            = 6;

    logic clk = 1'b0;
    logic rst;
    logic inj_valid;
    always #5 clk = ~clk;

    conv_group_accum_scheduler_if #(
        .SUM_WIDTH(SUM_WIDTH), .NUM_GROUPS_MAX(NUM_GROUPS_MAX),
        .OUT_WIDTH(OUT_WIDTH), .GW(GW)
    ) bus ();

    conv_group_accum_scheduler #(
        .SUM_WIDTH(SUM_WIDTH), .NUM_GROUPS_MAX(NUM_GROUPS_MAX),
        .OUT_WIDTH(OUT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .GW(GW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- datapath model: fixed latency, table of sums -------
    logic signed [SUM_WIDTH-1:0] tbl_a [0:255];
    logic signed [SUM_WIDTH-1:0] tbl_b [0:255];
    logic pv   [0:LAT-1];
    int   pidx [0:LAT-1];
    int   issue_cnt = 0;
    int   cyc       = 0;
    int   hs_cyc    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i]   <= 1'b0;
                pidx[i] <= 0;
            end
        end else begin
            pv[0]   <= bus.dp_valid;
            pidx[0] <= issue_cnt;
            for (int i = 1; i < LAT; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
        end
    end

    assign bus.dp_sum_valid = pv[LAT-1] | inj_valid;
    assign bus.dp_sum_a     = pv[LAT-1] ? tbl_a[pidx[LAT-1] & 255] : '0;
    assign bus.dp_sum_b     = pv[LAT-1] ? tbl_b[pidx[LAT-1] & 255] : '0;

    // ---------------- monitor ----------------
    longint got_a[$];
    longint got_b[$];
    int     got_last[$];
    int     iss_grp[$];
    int     iss_pix[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dp_valid) begin
            issue_cnt <= issue_cnt + 1;
            iss_grp.push_back(int'(bus.grp_idx));
            iss_pix.push_back(int'(bus.pix_idx));
        end
        if (bus.out_valid && bus.out_ready) begin
            got_a.push_back(longint'($signed(bus.out_sum_a)));
            got_b.push_back(longint'($signed(bus.out_sum_b)));
            got_last.push_back(int'(bus.out_last));
            hs_cyc <= cyc;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int g, input int n);
        bus.cfg_num_groups = GW'(g);
        bus.cfg_num_pixels = 16'(n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int found;
        found = 0;
        dcyc  = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus.done) begin
                found = 1;
                dcyc  = cyc;
                break;
            end
            tick();
        end
        if (found == 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int base, gbase, ibase, dcyc, found;

    initial begin
        rst = 1'b1;
        inj_valid = 1'b0;
        bus.start = 1'b0;
        bus.cfg_num_groups = '0;
        bus.cfg_num_pixels = '0;
        bus.src_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tbl_a[i] = '0;
            tbl_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        // ---- reset values ----
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_dp_valid", bus.dp_valid, 0);
        check("rst_grp", bus.grp_idx, 0);
        check("rst_pix", bus.pix_idx, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum_a", bus.out_sum_a, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_err", bus.err_underflow, 0);
        rst = 1'b0;
        tick();

        // ---- single group, continuous flow ----
        base = issue_cnt; gbase = got_a.size();
        tbl_a[base+0] = 5;   tbl_b[base+0] = 1;
        tbl_a[base+1] = -7;  tbl_b[base+1] = 2;
        tbl_a[base+2] = 100; tbl_b[base+2] = 3;
        bus.src_valid = 1'b1; bus.out_ready = 1'b1;
        start_job(1, 3);
        check("t1_busy", bus.busy, 1);
        check("t1_src_ready", bus.src_ready, 1);
        wait_done(60, dcyc);
        check("t1_count", got_a.size() - gbase, 3);
        if (got_a.size() - gbase == 3) begin
            check("t1_a0", got_a[gbase+0], 5);
            check("t1_b0", got_b[gbase+0], 1);
            check("t1_a1", got_a[gbase+1], -7);
            check("t1_b1", got_b[gbase+1], 2);
            check("t1_a2", got_a[gbase+2], 100);
            check("t1_b2", got_b[gbase+2], 3);
            check("t1_last0", got_last[gbase+0], 0);
            check("t1_last1", got_last[gbase+1], 0);
            check("t1_last2", got_last[gbase+2], 1);
        end
        check("t1_done_lat", dcyc, hs_cyc + 1);
        check("t1_busy_at_done", bus.busy, 0);
        tick();

        // ---- multi-group accumulation ----
        base = issue_cnt; gbase = got_a.size();
        for (int k = 0; k < 4; k++) tbl_a[base+k] = SUM_WIDTH'(k + 1);
        for (int k = 4; k < 8; k++) tbl_a[base+k] = -10;
        for (int k = 0; k < 8; k++) tbl_b[base+k] = 35'sh3FFFFFFFF;
        start_job(4, 2);
        wait_done(80, dcyc);
        check("t2_count", got_a.size() - gbase, 2);
        if (got_a.size() - gbase == 2) begin
            check("t2_a0", got_a[gbase+0], 10);
            check("t2_a1", got_a[gbase+1], -40);
            check("t2_b0", got_b[gbase+0], 64'sd68719476732);
            check("t2_b1", got_b[gbase+1], 64'sd68719476732);
        end
        tick();

        // ---- backpressure credits ----
        base = issue_cnt; gbase = got_a.size();
        for (int k = 0; k < 10; k++) begin
            tbl_a[base+k] = SUM_WIDTH'(100 + k);
            tbl_b[base+k] = SUM_WIDTH'(k);
        end
        bus.out_ready = 1'b0;
        start_job(1, 10);
        repeat (20) tick();
        check("t3_issued4", issue_cnt - base, 4);
        check("t3_src_ready_low", bus.src_ready, 0);
        check("t3_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (15) tick();
        check("t3_issued5", issue_cnt - base, 5);
        check("t3_src_ready_low2", bus.src_ready, 0);
        bus.out_ready = 1'b1;
        wait_done(200, dcyc);
        check("t3_count", got_a.size() - gbase, 10);
        if (got_a.size() - gbase == 10) begin
            check("t3_a0", got_a[gbase+0], 100);
            check("t3_a9", got_a[gbase+9], 109);
            check("t3_last8", got_last[gbase+8], 0);
            check("t3_last9", got_last[gbase+9], 1);
        end
        tick();

        // ---- source stalls ----
        base = issue_cnt; gbase = got_a.size(); ibase = iss_grp.size();
        for (int k = 0; k < 6; k++) begin
            tbl_a[base+k] = 1;
            tbl_b[base+k] = 2;
        end
        bus.src_valid = 1'b0;
        start_job(3, 2);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                found = 1;
                break;
            end
            bus.src_valid = ~bus.src_valid;
            tick();
        end
        check("t4_done_seen", found, 1);
        check("t4_issues", iss_grp.size() - ibase, 6);
        if (iss_grp.size() - ibase == 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("t4_grp%0d", k), iss_grp[ibase+k], k % 3);
                check($sformatf("t4_pix%0d", k), iss_pix[ibase+k], k / 3);
            end
        end
        if (got_a.size() - gbase == 2) begin
            check("t4_a0", got_a[gbase+0], 3);
            check("t4_b1", got_b[gbase+1], 6);
        end else begin
            check("t4_count", got_a.size() - gbase, 2);
        end
        bus.src_valid = 1'b1;
        tick();

        // ---- zero pixels ----
        base = issue_cnt;
        start_job(1, 0);
        check("t5_n0_done", bus.done, 1);
        check("t5_n0_busy", bus.busy, 0);
        repeat (3) tick();
        check("t5_n0_no_issue", issue_cnt - base, 0);
        check("t5_n0_done_low", bus.done, 0);

        // ---- zero groups acts as one, start while busy ignored ----
        base = issue_cnt; gbase = got_a.size();
        tbl_a[base+0] = 7; tbl_b[base+0] = 0;
        tbl_a[base+1] = 8; tbl_b[base+1] = 0;
        start_job(0, 2);
        tick();
        check("t5_busy_before_restart", bus.busy, 1);
        bus.cfg_num_groups = GW'(1);
        bus.cfg_num_pixels = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(80, dcyc);
        check("t5_g0_count", got_a.size() - gbase, 2);
        if (got_a.size() - gbase == 2) begin
            check("t5_g0_a0", got_a[gbase+0], 7);
            check("t5_g0_a1", got_a[gbase+1], 8);
            check("t5_g0_last1", got_last[gbase+1], 1);
        end
        repeat (10) tick();
        check("t5_g0_issues", issue_cnt - base, 2);
        check("t5_g0_idle", bus.busy, 0);

        // ---- underflow error ----
        bus.src_valid = 1'b0;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        check("t6_err_set", bus.err_underflow, 1);
        tick();
        check("t6_err_sticky", bus.err_underflow, 1);
        base = issue_cnt;
        tbl_a[base+0] = 1; tbl_b[base+0] = 1;
        bus.src_valid = 1'b1;
        start_job(1, 1);
        check("t6_err_cleared", bus.err_underflow, 0);
        wait_done(60, dcyc);
        tick();

        // ---- reset mid-drain ----
        base = issue_cnt;
        for (int k = 0; k < 4; k++) begin
            tbl_a[base+k] = 3;
            tbl_b[base+k] = 4;
        end
        bus.out_ready = 1'b0;
        start_job(2, 2);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t6_drain_out_valid", found, 1);
        check("t6_drain_busy", bus.busy, 1);
        check("t6_drain_pix", bus.pix_idx, 2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_out_valid", bus.out_valid, 0);
        check("t6_rst_out_sum_a", bus.out_sum_a, 0);
        check("t6_rst_out_sum_b", bus.out_sum_b, 0);
        check("t6_rst_out_last", bus.out_last, 0);
        check("t6_rst_src_ready", bus.src_ready, 0);
        check("t6_rst_dp_valid", bus.dp_valid, 0);
        check("t6_rst_grp", bus.grp_idx, 0);
        check("t6_rst_pix", bus.pix_idx, 0);
        check("t6_rst_done", bus.done, 0);
        check("t6_rst_err", bus.err_underflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) tick();
        check("t6_post_rst_err", bus.err_underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
